// File: rtl/imem_arb_pkg.sv
// Shared types for the instruction-memory arbiter: FSM state encoding and requester port indices.
package imem_arb_pkg;

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_LS = 1'b1;

endpackage

// File: rtl/imem_arb_if.sv
// Single-outstanding memory read port: the arbiter drives it (master) and the memory answers (slave).
interface imem_arb_if #(
    parameter int AW = 32,
    parameter int DW = 32
);

    logic          ren;
    logic [AW-1:0] addr;
    logic          rvd;
    logic [DW-1:0] data;

    modport master (output ren, output addr, input rvd, input data);
    modport slave  (input ren, input addr, output rvd, output data);

endinterface

// File: rtl/imem_arb_rr_arb2.sv
// Combinational 2-way picker; round-robin on ties by default, port0-first when IMEM_ARB_FIXED_PRIO_EN is defined.
module rr_arb2
    import imem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       grant_id,
    output logic       valid
);

    assign valid = |req;

`ifdef IMEM_ARB_FIXED_PRIO_EN
    always_comb begin
        grant_id = req[0] ? PORT_IF : PORT_LS;
    end
`else
    // On a tie the port that did not win last time goes first.
    always_comb begin
        grant_id = PORT_IF;
        if (req == 2'b11) begin
            grant_id = ~last;
        end else begin
            grant_id = req[1];
        end
    end
`endif

endmodule

// File: rtl/imem_arb.sv
// Two-requester arbiter (fetch = port0, load = port1) in front of a single-outstanding memory read port.
// Tie-break mode selected by IMEM_ARB_FIXED_PRIO_EN (undefined: round-robin).
module imem_arb
    import imem_arb_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_req0,
    input  logic [AW-1:0] i_addr0,
    output logic          o_gnt0,
    output logic          o_rvd0,
    output logic [DW-1:0] o_data0,
    input  logic          i_req1,
    input  logic [AW-1:0] i_addr1,
    output logic          o_gnt1,
    output logic          o_rvd1,
    output logic [DW-1:0] o_data1,
    imem_arb_if.master    mem
);

    state_t        state;
    state_t        state_nxt;
    logic          r_owner;
    logic          r_last;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_data;
    logic          pick_id;
    logic          pick_valid;

    rr_arb2 u_arb (
        .req      ({i_req1, i_req0}),
        .last     (r_last),
        .grant_id (pick_id),
        .valid    (pick_valid)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= INIT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            INIT:    state_nxt = IDLE;
            IDLE:    if (pick_valid) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (mem.rvd) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = INIT;
        endcase
    end

    // Owner/address are captured at the arbitration point; the return word only while waiting for it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_owner <= PORT_IF;
            r_last  <= PORT_LS;
            r_addr  <= '0;
            r_data  <= '0;
        end else begin
            if (state == IDLE && pick_valid) begin
                r_owner <= pick_id;
                r_addr  <= (pick_id == PORT_LS) ? i_addr1 : i_addr0;
`ifndef IMEM_ARB_FIXED_PRIO_EN
                r_last  <= pick_id;
`endif
            end
            if (state == WAIT && mem.rvd) begin
                r_data <= mem.data;
            end
        end
    end

    // Outputs decode only registered state, so each is a clean one-cycle pulse.
    assign mem.ren  = (state == ISSUE);
    assign mem.addr = (state == ISSUE) ? r_addr : '0;

    assign o_gnt0  = (state == ISSUE) && (r_owner == PORT_IF);
    assign o_gnt1  = (state == ISSUE) && (r_owner == PORT_LS);
    assign o_rvd0  = (state == RESP)  && (r_owner == PORT_IF);
    assign o_rvd1  = (state == RESP)  && (r_owner == PORT_LS);
    assign o_data0 = o_rvd0 ? r_data : '0;
    assign o_data1 = o_rvd1 ? r_data : '0;

endmodule
